// File: rtl/fp_pkg.sv
// Shared Fp / Fp2 definitions for the SQIsign lvl1 field, p = 5*2^248 - 1.
package fp_pkg;

  localparam int unsigned FP_W            = 255;
  localparam int unsigned LATENCY_FP2_ADD = 6;

  // 5*2^248 - 1 = 2^250 + (2^248 - 1)
  localparam logic [FP_W-1:0] P_LVL1 = {4'b0000, 1'b1, 2'b00, {248{1'b1}}};

  typedef struct packed {
    logic [FP_W-1:0] re;
    logic [FP_W-1:0] im;
  } fp2_t;

  // Modular add for reduced operands (a, b < p): one conditional subtract suffices.
  function automatic logic [FP_W-1:0] fp_add_mod(input logic [FP_W-1:0] a,
                                                 input logic [FP_W-1:0] b);
    logic [FP_W:0] sum;
    logic [FP_W:0] red;
    sum = {1'b0, a} + {1'b0, b};
    red = sum - {1'b0, P_LVL1};
    if (sum >= {1'b0, P_LVL1}) return red[FP_W-1:0];
    return sum[FP_W-1:0];
  endfunction

endpackage

// File: rtl/fp2_add.sv
// Fixed-latency Fp2 adder: D1 = A1+A2, D2 = B1+B2 (mod p), LATENCY_FP2_ADD cycles
// from operands presented to results valid. Active-high reset.
module fp2_add
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] A1,
  input  logic [FP_W-1:0] A2,
  input  logic [FP_W-1:0] B1,
  input  logic [FP_W-1:0] B2,
  output logic [FP_W-1:0] D1,
  output logic [FP_W-1:0] D2
);

  localparam int unsigned NPIPE = LATENCY_FP2_ADD - 1;

  fp2_t x_q, y_q;
  fp2_t sum;
  fp2_t pipe_q [NPIPE];

  // Operand register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= '{re: A1, im: B1};
      y_q <= '{re: A2, im: B2};
    end
  end

  // Reduction of the registered operands.
  always_comb begin
    sum    = '0;
    sum.re = fp_add_mod(x_q.re, y_q.re);
    sum.im = fp_add_mod(x_q.im, y_q.im);
  end

  // Result pipeline padding the adder out to its fixed latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPIPE; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= sum;
      for (int i = 1; i < NPIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign D1 = pipe_q[NPIPE-1].re;
  assign D2 = pipe_q[NPIPE-1].im;

endmodule

// File: rtl/fp2_result_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two so the extra pointer bit
// separates full from empty. Head reads zero while empty.
module fp2_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   wr_q, rd_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          full;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  // Credits are reserved at issue, so a push into a full FIFO is a design bug.
  assert property (@(posedge clk) disable iff (!rst) push |-> !full);

endmodule

// File: rtl/fp2_add_issue.sv
// Valid/ready issue and collect stage around fp2_add: a valid/tag delay line tracks
// in-flight ops, a credit counter guarantees result FIFO space before issue.
module fp2_add_issue
  import fp_pkg::*;
#(
  parameter int unsigned W     = FP_W,
  parameter int unsigned LAT   = LATENCY_FP2_ADD,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a0,
  input  logic [W-1:0]     in_a1,
  input  logic [W-1:0]     in_b0,
  input  logic [W-1:0]     in_b1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_d0,
  output logic [W-1:0]     out_d1,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned DW    = 2 * W + TAG_W;

  logic             issue, pop, push, fifo_empty;
  logic [OCC_W-1:0] occ_q, occ_d;
  // Stage 0 of the delay line is the live {issue, in_tag}; these are stages 1..LAT.
  logic [LAT-1:0]   dl_vld_q;
  logic [TAG_W-1:0] dl_tag_q [LAT];
  logic [W-1:0]     d1, d2;
  logic [DW-1:0]    head;

  assign in_ready = rst && (occ_q < OCC_W'(DEPTH));
  assign issue    = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign push     = dl_vld_q[LAT-1];

  fp2_add u_add (
    .clk (clk),
    .rst (~rst),
    .A1  (in_a0),
    .A2  (in_b0),
    .B1  (in_a1),
    .B2  (in_b1),
    .D1  (d1),
    .D2  (d2)
  );

  // Credit count: in-flight plus buffered operations.
  always_comb begin
    occ_d = occ_q + OCC_W'(issue) - OCC_W'(pop);
  end

  // Occupancy and delay-line valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= '0;
      dl_vld_q <= '0;
    end else begin
      occ_q    <= occ_d;
      dl_vld_q <= {dl_vld_q[LAT-2:0], issue};
    end
  end

  // Tags ride alongside the valids; qualified by dl_vld_q so no reset needed.
  always_ff @(posedge clk) begin
    dl_tag_q[0] <= in_tag;
    for (int i = 1; i < LAT; i++) dl_tag_q[i] <= dl_tag_q[i-1];
  end

  fp2_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({d1, d2, dl_tag_q[LAT-1]}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_d0    = head[DW-1 -: W];
  assign out_d1    = head[TAG_W +: W];
  assign out_tag   = head[TAG_W-1:0];
  assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_fp2_add_issue.sv
// Scoreboard bench for fp2_add_issue: stimulus pushes expected results, a monitor
// pops and compares on every accepted output.
module tb_fp2_add_issue;

  localparam int W     = 255;
  localparam int TAG_W = 4;

  typedef struct {
    logic [W-1:0]     d0;
    logic [W-1:0]     d1;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_d0, out_d1;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  logic [W-1:0] p = W'((256'd5 << 248) - 256'd1);
  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;

  fp2_add_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a0     (in_a0),
    .in_a1     (in_a1),
    .in_b0     (in_b0),
    .in_b1     (in_b1),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: compare every accepted result against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=%0h required=none", out_d0);
      end else begin
        e = exp_q.pop_front();
        chk("out_d0", out_d0, e.d0);
        chk("out_d1", out_d1, e.d1);
        chk("out_tag", W'(out_tag), W'(e.tag));
      end
    end
  end

  // Present one op and hold it until accepted; entered and left at posedge+1.
  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] b0, input logic [W-1:0] b1,
                      input logic [TAG_W-1:0] tag, input logic [W-1:0] e0,
                      input logic [W-1:0] e1, output int waits);
    bit done = 0;
    in_valid = 1'b1;
    in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1; in_tag = tag;
    waits = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{d0: e0, d1: e1, tag: tag});
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  // Edges from the issue edge until out_valid is seen; 6 means visible in cycle 7.
  task automatic lat_check(input string name);
    int k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    chk(name, W'(k), W'(6));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    chk("drain_queue", W'(exp_q.size()), '0);
    chk("drain_busy", W'(busy), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waits;
    int acc;

    // Reset state.
    #12;
    chk("rst_in_ready", W'(in_ready), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_out_d0", out_d0, '0);
    chk("rst_out_d1", out_d1, '0);
    chk("rst_out_tag", W'(out_tag), '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single op with latency and busy-after-pop.
    send(W'(3), W'(10), W'(5), W'(20), 4'd2, W'(8), W'(30), waits);
    chk("single_waits", W'(waits), '0);
    in_valid = 1'b0;
    lat_check("single_latency");
    @(posedge clk);
    @(negedge clk);
    chk("single_busy_after_pop", W'(busy), '0);
    @(posedge clk);
    #1;

    // Modular wrap.
    send(p - W'(1), p - W'(1), W'(2), W'(1), 4'd5, W'(1), W'(0), waits);
    send(p - W'(2), W'(7), p - W'(3), W'(9), 4'd6, p - W'(5), W'(16), waits);
    in_valid = 1'b0;
    drain();

    // Streaming: 20 back-to-back ops, in_ready must never drop.
    for (int i = 0; i < 20; i++) begin
      send(W'(i), W'(2 * i), W'(1000), W'(7), 4'(i), W'(i + 1000), W'(2 * i + 7), waits);
      chk("stream_no_stall", W'(waits), '0);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: exactly DEPTH accepts, head held stable.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_a0 = W'(500 + i); in_b0 = W'(i); in_a1 = W'(i); in_b1 = W'(3); in_tag = 4'(i);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{d0: W'(500 + 2 * i), d1: W'(i + 3), tag: 4'(i)});
        acc++;
      end
      if (out_valid) chk("bp_head_hold", out_d0, W'(500));
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", W'(acc), W'(8));
    @(negedge clk);
    chk("bp_in_ready_low", W'(in_ready), '0);
    chk("bp_out_valid", W'(out_valid), W'(1));
    chk("bp_head_tag", W'(out_tag), '0);
    @(posedge clk);
    #1;

    // Full with pop: in_ready returns the cycle after the pop; issue+pop holds occ.
    out_ready = 1'b1;
    in_a0 = W'(40); in_b0 = W'(2); in_a1 = W'(41); in_b1 = W'(3); in_tag = 4'd12;
    @(negedge clk);
    chk("full_pop_in_ready", W'(in_ready), '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_pop_in_ready", W'(in_ready), W'(1));
    if (in_ready) exp_q.push_back('{d0: W'(42), d1: W'(44), tag: 4'd12});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_a0 = W'(50); in_b0 = W'(5); in_a1 = W'(51); in_b1 = W'(6); in_tag = 4'd13;
    @(negedge clk);
    chk("issue_pop_in_ready", W'(in_ready), W'(1));
    if (in_ready) exp_q.push_back('{d0: W'(55), d1: W'(57), tag: 4'd13});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("refull_in_ready", W'(in_ready), '0);
    chk("refull_busy", W'(busy), W'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset mid-flight.
    send(W'(1), W'(1), W'(1), W'(1), 4'd1, W'(2), W'(2), waits);
    send(W'(2), W'(2), W'(2), W'(2), 4'd2, W'(4), W'(4), waits);
    send(W'(3), W'(3), W'(3), W'(3), 4'd3, W'(6), W'(6), waits);
    in_valid = 1'b1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    in_valid = 1'b0;
    chk("mid_rst_in_ready", W'(in_ready), '0);
    chk("mid_rst_out_valid", W'(out_valid), '0);
    chk("mid_rst_busy", W'(busy), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", W'(out_valid), '0);
    end
    @(posedge clk);
    #1;
    send(W'(100), W'(200), W'(11), W'(22), 4'd9, W'(111), W'(222), waits);
    in_valid = 1'b0;
    lat_check("post_rst_latency");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
